// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants and the decode table for the decode-stage
// control generator (ctrl_unit_seq) and its condition checker (cond_check).
// Contents: mode / opcode / ALU command / condition codes, {N,Z,C,V} flag
// bit positions, FSM state encodings, the control-word structs and the
// combinational decode function.
package ctrl_pkg;

    // Instruction class (mode field)
    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    // Data-processing opcodes
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // ALU commands driven to EX
    localparam logic [3:0] CMD_BR  = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    // Condition field encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions inside status = {N,Z,C,V}
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // FSM states
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    // Control word carried in the ID/EX register
    typedef struct packed {
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       b;
        logic       s;
        logic       imm;
        logic [3:0] exe_cmd;
    } ctrl_t;

    // Decoder result: control word plus legality
    typedef struct packed {
        logic  legal;
        ctrl_t ctrl;
    } dec_t;

    // Decode table: mode/opcode/S/I -> control word and legality
    function automatic dec_t decode(input logic [1:0] mode,
                                    input logic [3:0] opcode,
                                    input logic       s_in,
                                    input logic       i_in);
        dec_t d;
        d = '0;
        case (mode)
            MODE_DP: begin
                d.legal        = 1'b1;
                d.ctrl.wb_en   = 1'b1;
                d.ctrl.s       = s_in;
                d.ctrl.imm     = i_in;
                case (opcode)
                    OP_MOV:  d.ctrl.exe_cmd = CMD_MOV;
                    OP_MVN:  d.ctrl.exe_cmd = CMD_MVN;
                    OP_ADD:  d.ctrl.exe_cmd = CMD_ADD;
                    OP_ADC:  d.ctrl.exe_cmd = CMD_ADC;
                    OP_SUB:  d.ctrl.exe_cmd = CMD_SUB;
                    OP_SBC:  d.ctrl.exe_cmd = CMD_SBC;
                    OP_AND:  d.ctrl.exe_cmd = CMD_AND;
                    OP_ORR:  d.ctrl.exe_cmd = CMD_ORR;
                    OP_EOR:  d.ctrl.exe_cmd = CMD_EOR;
                    // Compare/test only update flags
                    OP_CMP: begin
                        d.ctrl.exe_cmd = CMD_SUB;
                        d.ctrl.wb_en   = 1'b0;
                        d.ctrl.s       = 1'b1;
                    end
                    OP_TST: begin
                        d.ctrl.exe_cmd = CMD_AND;
                        d.ctrl.wb_en   = 1'b0;
                        d.ctrl.s       = 1'b1;
                    end
                    default: d = '0;
                endcase
            end
            MODE_MEM: begin
                // S bit acts as L: 1 = load, 0 = store; address = base + offset
                d.legal         = 1'b1;
                d.ctrl.exe_cmd  = CMD_ADD;
                d.ctrl.imm      = 1'b1;
                d.ctrl.mem_r_en = s_in;
                d.ctrl.wb_en    = s_in;
                d.ctrl.mem_w_en = ~s_in;
            end
            MODE_BR: begin
                d.legal        = 1'b1;
                d.ctrl.b       = 1'b1;
                d.ctrl.imm     = 1'b1;
                d.ctrl.exe_cmd = CMD_BR;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cond_check.sv
// cond_check: combinational evaluation of the 4-bit condition field
// against the {N,Z,C,V} status flags.
// Ports: cond_i (condition field), status_i ({N,Z,C,V}), pass_o (1 = execute).
module cond_check
    import ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] status_i,
    output logic       pass_o
);

    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;

    assign n_s = status_i[FLAG_N];
    assign z_s = status_i[FLAG_Z];
    assign c_s = status_i[FLAG_C];
    assign v_s = status_i[FLAG_V];

    // Condition truth table
    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = z_s;
            COND_NE: pass_o = ~z_s;
            COND_CS: pass_o = c_s;
            COND_CC: pass_o = ~c_s;
            COND_MI: pass_o = n_s;
            COND_PL: pass_o = ~n_s;
            COND_VS: pass_o = v_s;
            COND_VC: pass_o = ~v_s;
            COND_HI: pass_o = c_s & ~z_s;
            COND_LS: pass_o = ~c_s | z_s;
            COND_GE: pass_o = (n_s == v_s);
            COND_LT: pass_o = (n_s != v_s);
            COND_GT: pass_o = ~z_s & (n_s == v_s);
            COND_LE: pass_o = z_s | (n_s != v_s);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_unit_seq.sv
// ctrl_unit_seq: registered decode-stage control generator.
// Decodes mode/opcode/S/I, checks the condition field, and loads the ID/EX
// control register (bubble on hazard, flush, failed condition or illegal).
// Memory ops park the unit in MEM_WAIT until mem_ack or timeout, stalling
// the front end meanwhile.
// Ports:
//   clk, rst (async, active low)
//   in_valid, cond, mode, opcode, s_in, i_in, status : instruction in ID
//   hazard, flush                                    : bubble requests
//   mem_ack                                          : memory completion
//   out_valid, wb_en, mem_r_en, mem_w_en, b, s_out, imm, exe_cmd : ID/EX
//   mem_req, stall_out                               : memory handshake / freeze
//   illegal, timeout                                 : one-cycle event pulses
module ctrl_unit_seq
    import ctrl_pkg::*;
#(
    parameter int EXE_CMD_W = 4,
    parameter int TIMEOUT_W = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [3:0]           cond,
    input  logic [1:0]           mode,
    input  logic [3:0]           opcode,
    input  logic                 s_in,
    input  logic                 i_in,
    input  logic [3:0]           status,
    input  logic                 hazard,
    input  logic                 flush,
    input  logic                 mem_ack,
    output logic                 out_valid,
    output logic                 wb_en,
    output logic                 mem_r_en,
    output logic                 mem_w_en,
    output logic                 b,
    output logic                 s_out,
    output logic                 imm,
    output logic [EXE_CMD_W-1:0] exe_cmd,
    output logic                 mem_req,
    output logic                 stall_out,
    output logic                 illegal,
    output logic                 timeout
);

    logic [0:0]           state_q,   state_d;
    logic [TIMEOUT_W-1:0] cnt_q,     cnt_d;
    ctrl_t                ctrl_q,    ctrl_d;
    logic                 valid_q,   valid_d;
    logic                 illegal_q, illegal_d;
    logic                 timeout_q, timeout_d;

    dec_t dec_s;
    logic pass_s;
    logic accept_s;
    logic go_s;
    logic load_s;
    logic is_mem_s;

    cond_check u_cond_check (
        .cond_i   (cond),
        .status_i (status),
        .pass_o   (pass_s)
    );

    assign dec_s    = decode(mode, opcode, s_in, i_in);
    assign is_mem_s = dec_s.ctrl.mem_r_en | dec_s.ctrl.mem_w_en;

    // A new instruction may be taken when idle, or on the ack cycle of a
    // pending access so the pipe loses no cycle between the two.
    assign accept_s = (state_q == ST_IDLE) | mem_ack;
    // Instruction is live in decode and its condition holds
    assign go_s     = in_valid & ~hazard & ~flush & pass_s;
    assign load_s   = go_s & dec_s.legal;

    // Next-state logic: accept / hold while waiting / abort on timeout
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        illegal_d = 1'b0;
        timeout_d = 1'b0;
        if (accept_s) begin
            illegal_d = go_s & ~dec_s.legal;
            cnt_d     = '0;
            if (load_s) begin
                ctrl_d  = dec_s.ctrl;
                valid_d = 1'b1;
            end else begin
                ctrl_d  = '0;
                valid_d = 1'b0;
            end
            if (load_s & is_mem_s) begin
                state_d = ST_MEM_WAIT;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (cnt_q == TIMEOUT_W'(TIMEOUT)) begin
            // Memory never answered: drop the access and insert a bubble
            state_d   = ST_IDLE;
            cnt_d     = '0;
            ctrl_d    = '0;
            valid_d   = 1'b0;
            timeout_d = 1'b1;
        end else begin
            // Stalled: ID/EX holds, hazard and flush are not looked at
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    // State, counter and ID/EX register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign out_valid = valid_q;
    assign wb_en     = ctrl_q.wb_en;
    assign mem_r_en  = ctrl_q.mem_r_en;
    assign mem_w_en  = ctrl_q.mem_w_en;
    assign b         = ctrl_q.b;
    assign s_out     = ctrl_q.s;
    assign imm       = ctrl_q.imm;
    assign exe_cmd   = EXE_CMD_W'(ctrl_q.exe_cmd);
    assign illegal   = illegal_q;
    assign timeout   = timeout_q;
    // Request comes straight from the state flop; the stall must drop in the
    // same cycle as the ack so the next fetch proceeds immediately.
    assign mem_req   = (state_q == ST_MEM_WAIT);
    assign stall_out = (state_q == ST_MEM_WAIT) & ~mem_ack;

endmodule

// File: tb/tb_ctrl_unit_seq.sv
// tb_ctrl_unit_seq: directed-vector bench for ctrl_unit_seq with
// hand-computed expected values.
module tb_ctrl_unit_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] cond;
    logic [1:0] mode;
    logic [3:0] opcode;
    logic       s_in;
    logic       i_in;
    logic [3:0] status;
    logic       hazard;
    logic       flush;
    logic       mem_ack;
    logic       out_valid, wb_en, mem_r_en, mem_w_en, b, s_out, imm;
    logic [3:0] exe_cmd;
    logic       mem_req, stall_out, illegal, timeout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ctrl_unit_seq #(
        .EXE_CMD_W (4),
        .TIMEOUT_W (4),
        .TIMEOUT   (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .cond      (cond),
        .mode      (mode),
        .opcode    (opcode),
        .s_in      (s_in),
        .i_in      (i_in),
        .status    (status),
        .hazard    (hazard),
        .flush     (flush),
        .mem_ack   (mem_ack),
        .out_valid (out_valid),
        .wb_en     (wb_en),
        .mem_r_en  (mem_r_en),
        .mem_w_en  (mem_w_en),
        .b         (b),
        .s_out     (s_out),
        .imm       (imm),
        .exe_cmd   (exe_cmd),
        .mem_req   (mem_req),
        .stall_out (stall_out),
        .illegal   (illegal),
        .timeout   (timeout)
    );

    // {out_valid, wb_en, mem_r_en, mem_w_en, b, s_out, imm, exe_cmd}
    wire [10:0] ctrl_v = {out_valid, wb_en, mem_r_en, mem_w_en, b, s_out, imm, exe_cmd};
    // {mem_req, stall_out, illegal, timeout}
    wire [3:0]  side_v = {mem_req, stall_out, illegal, timeout};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [3:0] c, input logic [1:0] m,
                             input logic [3:0] op, input logic s, input logic i);
        in_valid = v;
        cond     = c;
        mode     = m;
        opcode   = op;
        s_in     = s;
        i_in     = i;
    endtask

    // Opcode table: opcode, expected exe_cmd, expected wb_en, expected s_out (s_in=0)
    logic [3:0] op_tab  [11] = '{4'b1101, 4'b1111, 4'b0100, 4'b0101, 4'b0010, 4'b0110,
                                 4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1000};
    logic [3:0] cmd_tab [11] = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                                 4'b0110, 4'b0111, 4'b1000, 4'b0100, 4'b0110};
    logic       wb_tab  [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       s_tab   [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Condition table: cond, status {N,Z,C,V}, expected pass
    logic [3:0] cc_tab [16] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                                4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011,
                                4'b1100, 4'b1101, 4'b1110, 4'b1111};
    logic [3:0] st_tab [16] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b1000,
                                4'b0001, 4'b0001, 4'b0110, 4'b0010, 4'b1001, 4'b1000,
                                4'b0000, 4'b1000, 4'b0000, 4'b1111};
    logic       ps_tab [16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                                1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst     = 1'b0;
        hazard  = 1'b0;
        flush   = 1'b0;
        mem_ack = 1'b0;
        status  = 4'b0000;
        set_instr(1'b0, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0);
        #3;
        check_val("reset_ctrl", 32'(ctrl_v), 32'h0);
        check_val("reset_side", 32'(side_v), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // ADD, S=1
        set_instr(1'b1, 4'b1110, 2'b00, 4'b0100, 1'b1, 1'b0);
        tick();
        check_val("add_ctrl", 32'(ctrl_v), 32'(11'b1_1_0_0_0_1_0_0010));
        check_val("add_side", 32'(side_v), 32'h0);

        // CMP with I=1
        set_instr(1'b1, 4'b1110, 2'b00, 4'b1010, 1'b0, 1'b1);
        tick();
        check_val("cmp_ctrl", 32'(ctrl_v), 32'(11'b1_0_0_0_0_1_1_0100));

        // BEQ with Z=0: condition fails, bubble, no illegal
        status = 4'b0000;
        set_instr(1'b1, 4'b0000, 2'b10, 4'b0000, 1'b0, 1'b0);
        tick();
        check_val("beq_fail_ctrl", 32'(ctrl_v), 32'h0);
        check_val("beq_fail_side", 32'(side_v), 32'h0);

        // BEQ with Z=1: branch taken
        status = 4'b0100;
        tick();
        check_val("beq_pass_ctrl", 32'(ctrl_v), 32'(11'b1_0_0_0_1_0_1_0000));
        status = 4'b0000;

        // Full data-processing opcode table
        for (int k = 0; k < 11; k++) begin
            set_instr(1'b1, 4'b1110, 2'b00, op_tab[k], 1'b0, 1'b0);
            tick();
            check_val($sformatf("op_%b", op_tab[k]), 32'(ctrl_v),
                      32'({1'b1, wb_tab[k], 3'b000, s_tab[k], 1'b0, cmd_tab[k]}));
        end

        // Condition table, using MOV
        for (int k = 0; k < 16; k++) begin
            status = st_tab[k];
            set_instr(1'b1, cc_tab[k], 2'b00, 4'b1101, 1'b0, 1'b0);
            tick();
            check_val($sformatf("cond_%b_st_%b", cc_tab[k], st_tab[k]),
                      32'(out_valid), 32'(ps_tab[k]));
        end
        status = 4'b0000;

        // LDR, ack arrives in the 4th wait cycle; MOV follows on the ack edge
        set_instr(1'b1, 4'b1110, 2'b01, 4'b0000, 1'b1, 1'b0);
        tick();
        check_val("ldr_ctrl_w1", 32'(ctrl_v), 32'(11'b1_1_1_0_0_0_1_0010));
        check_val("ldr_side_w1", 32'(side_v), 32'(4'b1100));
        set_instr(1'b1, 4'b1110, 2'b00, 4'b1101, 1'b0, 1'b1);
        for (int k = 2; k <= 3; k++) begin
            tick();
            check_val($sformatf("ldr_ctrl_w%0d", k), 32'(ctrl_v), 32'(11'b1_1_1_0_0_0_1_0010));
            check_val($sformatf("ldr_side_w%0d", k), 32'(side_v), 32'(4'b1100));
        end
        tick();
        mem_ack = 1'b1;
        #1;
        check_val("ldr_ack_side", 32'(side_v), 32'(4'b1000));
        check_val("ldr_ack_ctrl", 32'(ctrl_v), 32'(11'b1_1_1_0_0_0_1_0010));
        tick();
        mem_ack = 1'b0;
        check_val("mov_after_ldr", 32'(ctrl_v), 32'(11'b1_1_0_0_0_0_1_0001));
        check_val("mov_after_ldr_side", 32'(side_v), 32'h0);

        // STR never acknowledged: 16 wait cycles then timeout.
        // hazard/flush pulsed early in the wait must not disturb anything.
        set_instr(1'b1, 4'b1110, 2'b01, 4'b0000, 1'b0, 1'b0);
        tick();
        set_instr(1'b1, 4'b1110, 2'b00, 4'b1101, 1'b0, 1'b0);
        flush  = 1'b1;
        hazard = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 4) begin
                flush    = 1'b0;
                hazard   = 1'b0;
                in_valid = 1'b0;
            end
            #1;
            check_val($sformatf("str_side_w%0d", k + 1), 32'(side_v), 32'(4'b1100));
            check_val($sformatf("str_ctrl_w%0d", k + 1), 32'(ctrl_v), 32'(11'b1_0_0_1_0_0_1_0010));
            tick();
        end
        #1;
        check_val("str_timeout_side", 32'(side_v), 32'(4'b0001));
        check_val("str_timeout_ctrl", 32'(ctrl_v), 32'h0);
        tick();
        check_val("str_timeout_done", 32'(side_v), 32'h0);

        // hazard then flush on a valid MOV: bubble both times
        set_instr(1'b1, 4'b1110, 2'b00, 4'b1101, 1'b0, 1'b0);
        hazard = 1'b1;
        tick();
        check_val("hazard_bubble", 32'(ctrl_v), 32'h0);
        hazard = 1'b0;
        flush  = 1'b1;
        tick();
        check_val("flush_bubble", 32'(ctrl_v), 32'h0);
        flush = 1'b0;

        // mode 11: one-cycle illegal pulse, no load
        set_instr(1'b1, 4'b1110, 2'b11, 4'b0000, 1'b0, 1'b0);
        tick();
        check_val("ill_mode_side", 32'(side_v), 32'(4'b0010));
        check_val("ill_mode_ctrl", 32'(ctrl_v), 32'h0);
        set_instr(1'b0, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0);
        tick();
        check_val("ill_mode_end", 32'(illegal), 32'h0);
        // Unassigned data-processing opcode is also illegal
        set_instr(1'b1, 4'b1110, 2'b00, 4'b0011, 1'b0, 1'b0);
        tick();
        check_val("ill_op_side", 32'(side_v), 32'(4'b0010));
        // Illegal with failing condition: no pulse
        set_instr(1'b1, 4'b1111, 2'b11, 4'b0000, 1'b0, 1'b0);
        tick();
        check_val("ill_nv_side", 32'(side_v), 32'h0);

        // Async reset in the middle of MEM_WAIT
        set_instr(1'b1, 4'b1110, 2'b01, 4'b0000, 1'b1, 1'b0);
        tick();
        set_instr(1'b0, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0);
        tick();
        check_val("pre_rst_side", 32'(side_v), 32'(4'b1100));
        #2;
        rst = 1'b0;
        #1;
        check_val("async_rst_side", 32'(side_v), 32'h0);
        check_val("async_rst_ctrl", 32'(ctrl_v), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        // Back in IDLE: a MOV loads without any memory request
        set_instr(1'b1, 4'b1110, 2'b00, 4'b1101, 1'b0, 1'b1);
        tick();
        check_val("post_rst_mov", 32'(ctrl_v), 32'(11'b1_1_0_0_0_0_1_0001));
        check_val("post_rst_side", 32'(side_v), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
